// File: rtl/rv32_pkg.sv
// Shared RV32 architectural constants and types, used by the decoder, the hazard unit,
// the forwarding unit and the register file.
package rv32_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// It performs the x0 masking, the same-cycle write bypass and the output mux.
module reg_file_read_port
   import rv32_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic [ADDR_W-1:0]                 addr,
   input  logic [2**ADDR_W-1:0][DATA_W-1:0]  regs,
   input  logic                              write_valid,
   input  logic [ADDR_W-1:0]                 write_addr,
   input  logic [DATA_W-1:0]                 write_data,
   output logic [DATA_W-1:0]                 data
);
   logic bypass_hit;

   // write_valid is already gated by reset, so a write pending during reset never forwards
   assign bypass_hit = (BYPASS != 0) && write_valid && (write_addr != '0) && (write_addr == addr);

   // NOTE: assign a default first in always_comb so that no path leaves data unassigned, which would infer a latch.
   always_comb begin
      data = regs[addr];
      if (bypass_hit) begin
         data = write_data;
      end
      if (addr == '0) begin
         data = '0;
      end
   end
endmodule

// File: rtl/reg_file_rv32.sv
// 32-entry RV32 register file with two combinational read ports, one synchronous
// write port, and an optional write-before-read bypass. x0 always reads as zero.
module reg_file_rv32
   import rv32_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE_ENABLE,
   input  logic [ADDR_W-1:0] WRITE_ADDR,
   input  logic [DATA_W-1:0] WRITE_DATA,
   input  logic [ADDR_W-1:0] OUT_ADDR1,
   input  logic [ADDR_W-1:0] OUT_ADDR2,
   output logic [DATA_W-1:0] DATA_OUT1,
   output logic [DATA_W-1:0] DATA_OUT2
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic                         write_valid;

   assign write_valid = RESET && WRITE_ENABLE;

   // NOTE: the whole array is cleared on reset so that no entry can ever read back as X.
   // NOTE: sequential state uses non-blocking assignments, so every reader sees the value from before the edge.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         regs <= '0;
      end else if (WRITE_ENABLE && (WRITE_ADDR != '0)) begin
         regs[WRITE_ADDR] <= WRITE_DATA;
      end
   end

   reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port1 (
      .addr        (OUT_ADDR1),
      .regs        (regs),
      .write_valid (write_valid),
      .write_addr  (WRITE_ADDR),
      .write_data  (WRITE_DATA),
      .data        (DATA_OUT1)
   );

   reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port2 (
      .addr        (OUT_ADDR2),
      .regs        (regs),
      .write_valid (write_valid),
      .write_addr  (WRITE_ADDR),
      .write_data  (WRITE_DATA),
      .data        (DATA_OUT2)
   );
endmodule

// File: tb/tb_reg_file_rv32.sv
// Self-checking bench for reg_file_rv32: directed vector table, hand-written reset
// sequences and randomized traffic checked against an array-based reference model.
module tb_reg_file_rv32;
   import rv32_pkg::*;

   logic      CLK = 1'b0;
   logic      RESET;
   logic      WRITE_ENABLE;
   reg_addr_t WRITE_ADDR;
   xlen_t     WRITE_DATA;
   reg_addr_t OUT_ADDR1;
   reg_addr_t OUT_ADDR2;
   xlen_t     DATA_OUT1;
   xlen_t     DATA_OUT2;

   int errors = 0;
   int checks = 0;

   xlen_t model [NUM_REGS];

   typedef struct {
      logic      rst;
      logic      we;
      reg_addr_t wa;
      xlen_t     wd;
      reg_addr_t a1;
      reg_addr_t a2;
      xlen_t     e1;
      xlen_t     e2;
   } vec_t;

   vec_t vecs [10];

   reg_file_rv32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .WRITE_ENABLE (WRITE_ENABLE),
      .WRITE_ADDR   (WRITE_ADDR),
      .WRITE_DATA   (WRITE_DATA),
      .OUT_ADDR1    (OUT_ADDR1),
      .OUT_ADDR2    (OUT_ADDR2),
      .DATA_OUT1    (DATA_OUT1),
      .DATA_OUT2    (DATA_OUT2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input xlen_t act, input xlen_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive a cycle's inputs just after the falling edge, then let the logic settle.
   task automatic drive(input logic rst, input logic we, input reg_addr_t wa, input xlen_t wd,
                        input reg_addr_t a1, input reg_addr_t a2);
      @(negedge CLK);
      RESET = rst; WRITE_ENABLE = we; WRITE_ADDR = wa; WRITE_DATA = wd;
      OUT_ADDR1 = a1; OUT_ADDR2 = a2;
      #1;
   endtask

   // Reference model: what a read port must show for the inputs currently driven.
   function automatic xlen_t model_read(input reg_addr_t a);
      if (a == 5'd0) return '0;
      if (RESET && WRITE_ENABLE && WRITE_ADDR != 5'd0 && WRITE_ADDR == a) return WRITE_DATA;
      return model[int'(a)];
   endfunction

   // Advance through the rising edge and apply the architectural update to the model.
   task automatic edge_update();
      @(posedge CLK);
      if (!RESET) begin
         for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      end else if (WRITE_ENABLE && WRITE_ADDR != 5'd0) begin
         model[int'(WRITE_ADDR)] = WRITE_DATA;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

      // Directed vectors; expectations are the read values before each cycle's edge.
      vecs[0] = '{1'b1, 1'b1, 5'd1, 32'd42,         5'd1, 5'd0, 32'd42,         32'd0};
      vecs[1] = '{1'b1, 1'b0, 5'd1, 32'd999,        5'd1, 5'd0, 32'd42,         32'd0};
      vecs[2] = '{1'b1, 1'b1, 5'd2, 32'd100,        5'd3, 5'd1, 32'd0,          32'd42};
      vecs[3] = '{1'b1, 1'b0, 5'd0, 32'd0,          5'd2, 5'd1, 32'd100,        32'd42};
      vecs[4] = '{1'b1, 1'b1, 5'd0, 32'd123,        5'd0, 5'd1, 32'd0,          32'd42};
      vecs[5] = '{1'b1, 1'b0, 5'd0, 32'd0,          5'd0, 5'd1, 32'd0,          32'd42};
      vecs[6] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF,   5'd5, 5'd5, 32'hDEADBEEF,   32'hDEADBEEF};
      vecs[7] = '{1'b1, 1'b0, 5'd5, 32'h00001111,   5'd5, 5'd2, 32'hDEADBEEF,   32'd100};
      vecs[8] = '{1'b0, 1'b1, 5'd5, 32'd55,         5'd5, 5'd1, 32'hDEADBEEF,   32'd42};
      vecs[9] = '{1'b1, 1'b0, 5'd0, 32'd0,          5'd5, 5'd1, 32'd0,          32'd0};

      // Initial reset, then every address on both ports must read zero.
      drive(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'd0, 5'd0);
      edge_update();
      for (int a = 0; a < NUM_REGS; a++) begin
         drive(1'b1, 1'b0, 5'(a), 32'hA5A5_A5A5, 5'(a), 5'(31 - a));
         check($sformatf("reset_p1_x%0d", a), DATA_OUT1, 32'd0);
         check($sformatf("reset_p2_x%0d", 31 - a), DATA_OUT2, 32'd0);
         edge_update();
      end

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
         check($sformatf("vec%0d_p1", i), DATA_OUT1, vecs[i].e1);
         check($sformatf("vec%0d_p2", i), DATA_OUT2, vecs[i].e2);
         edge_update();
      end

      // Reset in the middle of operation: load x1..x31 with index*3, then reset.
      for (int a = 1; a < NUM_REGS; a++) begin
         drive(1'b1, 1'b1, 5'(a), xlen_t'(a * 3), 5'(a - 1), 5'(a));
         check($sformatf("load_p1_x%0d", a - 1), DATA_OUT1, (a == 1) ? 32'd0 : xlen_t'((a - 1) * 3));
         check($sformatf("load_p2_x%0d", a), DATA_OUT2, xlen_t'(a * 3));
         edge_update();
      end
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
      check("loaded_x31", DATA_OUT1, 32'd93);
      check("loaded_x17", DATA_OUT2, 32'd51);
      edge_update();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
      edge_update();
      for (int a = 0; a < NUM_REGS; a++) begin
         drive(1'b1, 1'b0, 5'd0, 32'd0, 5'(a), 5'(a));
         check($sformatf("midreset_p1_x%0d", a), DATA_OUT1, 32'd0);
         check($sformatf("midreset_p2_x%0d", a), DATA_OUT2, 32'd0);
         edge_update();
      end
      drive(1'b1, 1'b1, 5'd7, 32'h0000_ABCD, 5'd8, 5'd6);
      edge_update();
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
      check("post_reset_write_x7", DATA_OUT1, 32'h0000_ABCD);
      check("post_reset_x8_zero", DATA_OUT2, 32'd0);
      edge_update();

      // Randomized traffic against the reference model; occasional resets included.
      for (int n = 0; n < 400; n++) begin
         logic      r_rst;
         logic      r_we;
         reg_addr_t r_wa, r_a1, r_a2;
         r_rst = ($urandom_range(0, 24) != 0);
         r_we  = ($urandom_range(0, 3) != 0);
         r_wa  = 5'($urandom_range(0, 31));
         r_a1  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
         r_a2  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
         drive(r_rst, r_we, r_wa, $urandom, r_a1, r_a2);
         check($sformatf("rand%0d_p1", n), DATA_OUT1, model_read(r_a1));
         check($sformatf("rand%0d_p2", n), DATA_OUT2, model_read(r_a2));
         edge_update();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
